// File: rtl/axi_aes_pkg.sv
// Shared constants, status record layout and status-word formatting for the AES S2MM status path.
package axi_aes_pkg;

  localparam int unsigned STS_WORDS = 5;
  localparam int unsigned CNT_W     = 23;
  localparam int unsigned SEQ_W     = 16;
  localparam int unsigned WIDX_W    = 3;
  localparam int unsigned SUM_W     = CNT_W + 1;

  localparam logic [31:0]      STS_FLAG = 32'h5000_0000;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             err;
    logic [SEQ_W-1:0] seq;
  } sts_rec_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } sts_state_t;

  // Status word idx of the five-word record presented to the DMA
  function automatic logic [31:0] sts_word(input sts_rec_t rec, input logic [WIDX_W-1:0] idx);
    case (idx)
      3'd0:    sts_word = STS_FLAG;
      3'd1:    sts_word = {16'h0, rec.seq};
      3'd2:    sts_word = {30'h0, rec.ovf, rec.err};
      3'd4:    sts_word = {9'h0, rec.count};
      default: sts_word = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/axi_aes_sts_fifo.sv
// Small synchronous FIFO of completed-frame status records with registered occupancy flags.
module axi_aes_sts_fifo
  import axi_aes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  sts_rec_t din,
  input  logic     pop,
  output sts_rec_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  sts_rec_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & (count != CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_aes_s2mm_sts.sv
// AES-to-DMA S2MM pass-through that counts frame bytes/errors and emits a five-word status record per frame.
module axi_aes_s2mm_sts
  import axi_aes_pkg::*;
#(
  parameter int unsigned C_S_AXIS_S2MM_TDATA_WIDTH     = 128,
  parameter int unsigned C_S_AXIS_S2MM_STS_TDATA_WIDTH = 32,
  parameter int unsigned C_STS_FIFO_DEPTH              = 4
) (
  input  logic                                       s_axi_s2mm_aclk,
  input  logic                                       s2mm_reset,
  input  logic [C_S_AXIS_S2MM_TDATA_WIDTH-1:0]       aes_tdata,
  input  logic [C_S_AXIS_S2MM_TDATA_WIDTH/8-1:0]     aes_tkeep,
  input  logic                                       aes_tvalid,
  input  logic                                       aes_tlast,
  input  logic                                       aes_terr,
  output logic                                       aes_tready,
  output logic [C_S_AXIS_S2MM_TDATA_WIDTH-1:0]       m_axis_s2mm_tdata,
  output logic [C_S_AXIS_S2MM_TDATA_WIDTH/8-1:0]     m_axis_s2mm_tkeep,
  output logic                                       m_axis_s2mm_tvalid,
  output logic                                       m_axis_s2mm_tlast,
  input  logic                                       m_axis_s2mm_tready,
  output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH-1:0]   s_axis_s2mm_sts_tdata,
  output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH/8-1:0] s_axis_s2mm_sts_tkeep,
  output logic                                       s_axis_s2mm_sts_tvalid,
  output logic                                       s_axis_s2mm_sts_tlast,
  input  logic                                       s_axis_s2mm_sts_tready
);

  localparam int unsigned KW = C_S_AXIS_S2MM_TDATA_WIDTH / 8;
  localparam int unsigned SW = C_S_AXIS_S2MM_STS_TDATA_WIDTH;

  function automatic logic [SUM_W-1:0] popcount(input logic [KW-1:0] k);
    popcount = '0;
    for (int i = 0; i < KW; i++) popcount = popcount + SUM_W'(k[i]);
  endfunction

  logic             fifo_full;
  logic             fifo_empty;
  logic             full_eff;
  logic             stall;
  logic             beat_hs;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] byte_count;
  logic             err;
  logic             ovf;
  logic [SEQ_W-1:0] seq;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] count_next;
  logic             ovf_next;
  logic             err_next;
  sts_rec_t         push_rec;
  sts_rec_t         head_rec;

  sts_state_t        state;
  sts_state_t        state_next;
  logic [WIDX_W-1:0] widx;
  logic [WIDX_W-1:0] widx_next;
  logic [SW-1:0]     sts_data;
  logic [SW-1:0]     sts_data_next;
  logic              sts_last;
  logic              sts_last_next;

  // Pass-through data path; only a closing beat waits for FIFO space
  assign full_eff           = fifo_full & ~s2mm_reset;
  assign stall              = aes_tvalid & aes_tlast & full_eff;
  assign m_axis_s2mm_tdata  = aes_tdata;
  assign m_axis_s2mm_tkeep  = aes_tkeep;
  assign m_axis_s2mm_tlast  = aes_tlast;
  assign m_axis_s2mm_tvalid = aes_tvalid & ~stall;
  assign aes_tready         = m_axis_s2mm_tready & ~stall;
  assign beat_hs            = aes_tvalid & aes_tready;
  assign push               = beat_hs & aes_tlast;

  // Saturating byte count; ovf only when a beat would exceed the maximum
  always_comb begin
    sum        = {1'b0, byte_count} + popcount(aes_tkeep);
    count_next = sum[CNT_W-1:0];
    ovf_next   = ovf;
    err_next   = err | aes_terr;
    if (sum > SUM_W'(CNT_MAX)) begin
      count_next = CNT_MAX;
      ovf_next   = 1'b1;
    end
  end

  assign push_rec = '{count: count_next, ovf: ovf_next, err: err_next, seq: seq};

  always_ff @(posedge s_axi_s2mm_aclk) begin
    if (s2mm_reset) begin
      byte_count <= '0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      seq        <= '0;
    end else if (beat_hs) begin
      if (aes_tlast) begin
        byte_count <= '0;
        err        <= 1'b0;
        ovf        <= 1'b0;
        seq        <= seq + SEQ_W'(1);
      end else begin
        byte_count <= count_next;
        err        <= err_next;
        ovf        <= ovf_next;
      end
    end
  end

  axi_aes_sts_fifo #(
    .DEPTH (C_STS_FIFO_DEPTH)
  ) u_fifo (
    .clk   (s_axi_s2mm_aclk),
    .rst   (s2mm_reset),
    .push  (push),
    .din   (push_rec),
    .pop   (pop),
    .dout  (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Status sequencer: words are preloaded so tdata holds while the DMA stalls
  always_comb begin
    state_next    = state;
    widx_next     = widx;
    sts_data_next = sts_data;
    sts_last_next = sts_last;
    pop           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next    = ST_SEND;
          widx_next     = '0;
          sts_data_next = SW'(sts_word(head_rec, '0));
          sts_last_next = 1'b0;
        end
      end
      ST_SEND: begin
        if (s_axis_s2mm_sts_tready) begin
          if (widx == WIDX_W'(STS_WORDS - 1)) begin
            state_next    = ST_IDLE;
            widx_next     = '0;
            sts_last_next = 1'b0;
            pop           = 1'b1;
          end else begin
            widx_next     = widx + WIDX_W'(1);
            sts_data_next = SW'(sts_word(head_rec, widx + WIDX_W'(1)));
            sts_last_next = ((widx + WIDX_W'(1)) == WIDX_W'(STS_WORDS - 1));
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_s2mm_aclk) begin
    if (s2mm_reset) begin
      state    <= ST_IDLE;
      widx     <= '0;
      sts_data <= '0;
      sts_last <= 1'b0;
    end else begin
      state    <= state_next;
      widx     <= widx_next;
      sts_data <= sts_data_next;
      sts_last <= sts_last_next;
    end
  end

  assign s_axis_s2mm_sts_tvalid = (state == ST_SEND);
  assign s_axis_s2mm_sts_tdata  = sts_data;
  assign s_axis_s2mm_sts_tlast  = sts_last;
  assign s_axis_s2mm_sts_tkeep  = {(SW/8){1'b1}};

endmodule

// File: tb/tb_axi_aes_s2mm_sts.sv
// Bench for axi_aes_s2mm_sts: directed frame table, stall/saturation/reset sequences and randomized traffic vs a record-queue model.
module tb_axi_aes_s2mm_sts;

  localparam int DEPTH = 4;
  localparam logic [22:0] CMAX = 23'h7FFFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] aes_tdata;
  logic [15:0]  aes_tkeep;
  logic         aes_tvalid, aes_tlast, aes_terr, aes_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tvalid, m_tlast, m_tready;
  logic [31:0]  sts_tdata;
  logic [3:0]   sts_tkeep;
  logic         sts_tvalid, sts_tlast, sts_tready;

  always #5 clk = ~clk;

  axi_aes_s2mm_sts dut (
    .s_axi_s2mm_aclk        (clk),
    .s2mm_reset             (rst),
    .aes_tdata              (aes_tdata),
    .aes_tkeep              (aes_tkeep),
    .aes_tvalid             (aes_tvalid),
    .aes_tlast              (aes_tlast),
    .aes_terr               (aes_terr),
    .aes_tready             (aes_tready),
    .m_axis_s2mm_tdata      (m_tdata),
    .m_axis_s2mm_tkeep      (m_tkeep),
    .m_axis_s2mm_tvalid     (m_tvalid),
    .m_axis_s2mm_tlast      (m_tlast),
    .m_axis_s2mm_tready     (m_tready),
    .s_axis_s2mm_sts_tdata  (sts_tdata),
    .s_axis_s2mm_sts_tkeep  (sts_tkeep),
    .s_axis_s2mm_sts_tvalid (sts_tvalid),
    .s_axis_s2mm_sts_tlast  (sts_tlast),
    .s_axis_s2mm_sts_tready (sts_tready)
  );

  typedef struct {
    logic [22:0] cnt;
    logic        err;
    logic        ovf;
    logic [15:0] seq;
    int          push_cyc;
  } rec_t;

  typedef struct {
    int          nb;
    logic [15:0] keep [4];
    logic [3:0]  errm;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w4;
  } vec_t;

  rec_t        exp_q[$];
  vec_t        tbl[5];
  int          errors = 0, checks = 0;
  int          occ = 0, cyc = 0, last_pop = -10, widx = 0;
  logic [22:0] m_cnt = '0;
  logic        m_err = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_seq = '0;
  logic [31:0] got[5];
  logic [31:0] prev_data = '0;
  logic [15:0] prev_rec_seq = '0;
  bit          rec_done = 0, last_hs = 0, prev_stall = 0, have_prev = 0, wrap_seen = 0, rand_rdy = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, 128'(act), 128'(exp));
  endtask

  function automatic logic [31:0] exp_word(input rec_t r, input int i);
    case (i)
      0:       return 32'h5000_0000;
      1:       return {16'h0, r.seq};
      2:       return {30'h0, r.ovf, r.err};
      4:       return {9'h0, r.cnt};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    exp_q.delete();
    occ = 0; widx = 0; last_pop = -10;
    m_cnt = '0; m_err = 1'b0; m_ovf = 1'b0; m_seq = '0;
    prev_stall = 0; have_prev = 0;
  endtask

  // One clock: entered at a falling edge with inputs applied, checks #1 later, returns at the next falling edge
  task automatic step();
    bit   exp_full, exp_stall, hs, exp_v;
    rec_t r;
    int   sum;
    if (rand_rdy) begin
      m_tready   = ($urandom_range(0, 3) != 0);
      sts_tready = ($urandom_range(0, 1) != 0);
    end
    #1;
    exp_full  = !rst && (occ == DEPTH);
    exp_stall = aes_tvalid && aes_tlast && exp_full;
    check1("m_tvalid", m_tvalid, aes_tvalid && !exp_stall);
    check1("aes_tready", aes_tready, m_tready && !exp_stall);
    check("m_tdata", m_tdata, aes_tdata);
    check("m_tkeep", 128'(m_tkeep), 128'(aes_tkeep));
    check1("m_tlast", m_tlast, aes_tlast);
    hs = aes_tvalid && m_tready && !exp_stall;
    last_hs = hs;
    if (rst) begin
      model_clear();
    end else begin
      exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].push_cyc + 2) && (cyc >= last_pop + 2);
      check1("sts_tvalid", sts_tvalid, exp_v);
      check("sts_tkeep", 128'(sts_tkeep), 128'(4'hF));
      if (exp_v) begin
        check("sts_tdata", 128'(sts_tdata), 128'(exp_word(exp_q[0], widx)));
        check1("sts_tlast", sts_tlast, widx == 4);
        if (prev_stall) check("sts_stable", 128'(sts_tdata), 128'(prev_data));
      end else begin
        check1("sts_tlast_idle", sts_tlast, 1'b0);
      end
      prev_stall = exp_v && !sts_tready;
      prev_data  = sts_tdata;
      if (exp_v && sts_tready) begin
        got[widx] = sts_tdata;
        widx++;
        if (widx == 5) begin
          if (have_prev && prev_rec_seq == 16'hFFFF) begin
            check("seq_wrap", 128'(got[1]), 128'(32'h0));
            wrap_seen = 1;
          end
          prev_rec_seq = exp_q[0].seq;
          have_prev = 1;
          void'(exp_q.pop_front());
          occ--; last_pop = cyc; widx = 0; rec_done = 1;
        end
      end
      if (hs) begin
        sum = int'(m_cnt) + $countones(aes_tkeep);
        if (sum > int'(CMAX)) begin
          m_cnt = CMAX; m_ovf = 1'b1;
        end else begin
          m_cnt = 23'(sum);
        end
        m_err = m_err | aes_terr;
        if (aes_tlast) begin
          r.cnt = m_cnt; r.err = m_err; r.ovf = m_ovf; r.seq = m_seq; r.push_cyc = cyc;
          exp_q.push_back(r);
          occ++; m_seq = m_seq + 16'd1;
          m_cnt = '0; m_err = 1'b0; m_ovf = 1'b0;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [15:0] keep, input logic last, input logic terr, input int budget);
    int n = 0;
    aes_tvalid = 1'b1; aes_tkeep = keep; aes_tlast = last; aes_terr = terr;
    aes_tdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
    do begin
      step(); n++;
    end while (!last_hs && n < budget);
    check1("beat_timeout", last_hs, 1'b1);
    aes_tvalid = 1'b0; aes_tlast = 1'b0; aes_terr = 1'b0;
  endtask

  task automatic wait_rec(input int budget);
    int n = 0;
    while (!rec_done && n < budget) begin step(); n++; end
    check1("rec_timeout", rec_done, 1'b1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin step(); n++; end
    check("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic set_vec(input int i, input int nb, input logic [15:0] k0, input logic [15:0] k1,
                         input logic [15:0] k2, input logic [3:0] errm,
                         input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w4);
    tbl[i].nb = nb;
    tbl[i].keep[0] = k0; tbl[i].keep[1] = k1; tbl[i].keep[2] = k2; tbl[i].keep[3] = 16'h0;
    tbl[i].errm = errm; tbl[i].w1 = w1; tbl[i].w2 = w2; tbl[i].w4 = w4;
  endtask

  initial begin
    int n;
    int k;
    int nb;
    rst = 1'b1; aes_tdata = '0; aes_tkeep = '0; aes_tvalid = 1'b0; aes_tlast = 1'b0; aes_terr = 1'b0;
    m_tready = 1'b1; sts_tready = 1'b1;

    // Records after reset: expected seq, flags and byte counts
    set_vec(0, 3, 16'hFFFF, 16'hFFFF, 16'h00FF, 4'b0000, 32'h0, 32'h0, 32'h28);
    set_vec(1, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0010, 32'h1, 32'h1, 32'h30);
    set_vec(2, 2, 16'h000F, 16'h0001, 16'h0000, 4'b0000, 32'h2, 32'h0, 32'h5);
    set_vec(3, 2, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 32'h3, 32'h0, 32'h0);
    set_vec(4, 1, 16'h7FFF, 16'h0000, 16'h0000, 4'b0001, 32'h4, 32'h1, 32'hF);

    @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();
    check1("reset_sts_tvalid", sts_tvalid, 1'b0);
    check1("reset_sts_tlast", sts_tlast, 1'b0);

    for (int i = 0; i < 5; i++) begin
      rec_done = 0;
      for (int b = 0; b < tbl[i].nb; b++)
        send_beat(tbl[i].keep[b], b == tbl[i].nb - 1, tbl[i].errm[b], 20);
      wait_rec(40);
      check("tbl_w0", 128'(got[0]), 128'(32'h5000_0000));
      check("tbl_w1", 128'(got[1]), 128'(tbl[i].w1));
      check("tbl_w2", 128'(got[2]), 128'(tbl[i].w2));
      check("tbl_w3", 128'(got[3]), 128'(32'h0));
      check("tbl_w4", 128'(got[4]), 128'(tbl[i].w4));
    end

    // Four buffered records fill the FIFO; the fifth closing beat waits for the first record to drain
    sts_tready = 1'b0;
    for (int f = 0; f < 4; f++) send_beat(16'hFFFF, 1'b1, 1'b0, 10);
    aes_tvalid = 1'b1; aes_tlast = 1'b1; aes_tkeep = 16'h00FF;
    for (int i = 0; i < 3; i++) begin
      step();
      check1("fifth_stalled", last_hs, 1'b0);
    end
    sts_tready = 1'b1;
    n = 0;
    do begin step(); n++; end while (!last_hs && n < 20);
    check("stall_release_cycles", 128'(n), 128'(6));
    aes_tvalid = 1'b0; aes_tlast = 1'b0;
    drain(200);

    // Saturation from a preset count
    force dut.byte_count = 23'h7FFFF8;
    step();
    release dut.byte_count;
    m_cnt = 23'h7FFFF8;
    rec_done = 0;
    send_beat(16'hFFFF, 1'b1, 1'b0, 10);
    wait_rec(40);
    check("sat_w4", 128'(got[4]), 128'(32'h007F_FFFF));
    check("sat_w2", 128'(got[2]), 128'(32'h2));

    // Randomized traffic across the sequence-number wrap
    force dut.seq = 16'hFFFC;
    step();
    release dut.seq;
    m_seq = 16'hFFFC;
    rand_rdy = 1;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) step();
        k = $urandom_range(0, 16);
        send_beat(16'((32'h1 << k) - 32'h1), b == nb - 1, $urandom_range(0, 7) == 0, 200);
      end
    end
    drain(3000);
    rand_rdy = 0;
    check1("seq_wrap_seen", wrap_seen, 1'b1);

    // Reset in the middle of a record and of a partial frame
    m_tready = 1'b1; sts_tready = 1'b0;
    send_beat(16'hFFFF, 1'b1, 1'b0, 10);
    send_beat(16'hFFFF, 1'b1, 1'b0, 10);
    send_beat(16'hFFFF, 1'b0, 1'b0, 10);
    sts_tready = 1'b1;
    n = 0;
    while (widx != 2 && n < 20) begin step(); n++; end
    check("reach_word2", 128'(widx), 128'(2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("sts_tvalid_after_reset", sts_tvalid, 1'b0);
    step();
    check1("sts_idle_after_reset", sts_tvalid, 1'b0);
    rec_done = 0;
    send_beat(16'h0003, 1'b1, 1'b0, 10);
    wait_rec(40);
    check("post_reset_seq", 128'(got[1]), 128'(32'h0));
    check("post_reset_count", 128'(got[4]), 128'(32'h2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_aes_s2mm_sts.md
AXI_AES_S2MM_STS -- requirements
Module: axi_aes_s2mm_sts

Interface
REQ-001 SHALL have parameter C_S_AXIS_S2MM_TDATA_WIDTH, default 128, width of the S2MM data path in bits.
REQ-002 SHALL have parameter C_S_AXIS_S2MM_STS_TDATA_WIDTH, default 32, width of the status word in bits.
REQ-003 SHALL have parameter C_STS_FIFO_DEPTH, default 4, number of frame records buffered (power of two).
REQ-004 SHALL have ports:
 s_axi_s2mm_aclk  in  1  sole clock, all logic rising-edge.
 s2mm_reset  in  1  reset, synchronous and active-high.
 aes_tdata  in  128  AES output data.
 aes_tkeep  in  16  byte enables, contiguous from bit 0.
 aes_tvalid  in  1  AES beat valid.
 aes_tlast  in  1  last beat of frame.
 aes_terr  in  1  AES error on this beat.
 aes_tready  out  1  ready to AES core.
 m_axis_s2mm_tdata  out  128  data to DMA S2MM.
 m_axis_s2mm_tkeep  out  16  byte enables to DMA.
 m_axis_s2mm_tvalid  out  1  valid to DMA.
 m_axis_s2mm_tlast  out  1  last to DMA.
 m_axis_s2mm_tready  in  1  DMA ready.
 s_axis_s2mm_sts_tdata  out  32  status word.
 s_axis_s2mm_sts_tkeep  out  4  status byte enables.
 s_axis_s2mm_sts_tvalid  out  1  status valid.
 s_axis_s2mm_sts_tlast  out  1  last status word.
 s_axis_s2mm_sts_tready  in  1  DMA status ready.

Function
REQ-005 Data path SHALL be combinational pass-through: m_axis tdata/tkeep/tlast = aes equivalents; no added latency.
REQ-006 stall = aes_tvalid & aes_tlast & fifo_full; m_axis_s2mm_tvalid = aes_tvalid & ~stall; aes_tready = m_axis_s2mm_tready & ~stall.
REQ-007 Beat handshake = aes_tvalid & aes_tready; only handshaked beats affect counters.
REQ-008 Byte counter (23 bits) SHALL add popcount(aes_tkeep) (0..16) per handshaked beat; saturates at 0x7FFFFF and sets sticky overflow flag.
REQ-009 Error flag SHALL be sticky OR of aes_terr over handshaked beats of the current frame.
REQ-010 On handshaked tlast beat, a record {count including that beat, err, ovf, seq} SHALL be pushed to FIFO; count/err/ovf clear to 0 the same edge; seq increments mod 2^16.
REQ-011 FIFO full is evaluated from registered occupancy only; a pop in the same cycle does not lift stall.
REQ-012 FSM states IDLE, SEND. IDLE->SEND when FIFO not empty; SEND->IDLE after word 4 handshake, with FIFO pop at that edge; one IDLE cycle always separates records.
REQ-013 s_axis_s2mm_sts_tvalid = (state==SEND); word index 0..4 advances on sts tvalid&tready; tdata stable while stalled.
REQ-014 Words: 0 = 0x5000_0000; 1 = {16'h0, seq}; 2 = {30'h0, ovf, err}; 3 = 0; 4 = {9'h0, count[22:0]}.
REQ-015 sts_tkeep SHALL be 4'hF constant; sts_tlast = 1 only on word 4.
REQ-016 Latency: tlast handshake in cycle N -> sts_tvalid first high in cycle N+2 (FIFO previously empty, FSM IDLE).
REQ-017 Frame of zero-popcount beats only SHALL report count 0.

Reset
REQ-018 On s2mm_reset: FSM IDLE, word index 0, FIFO empty, count/err/ovf/seq 0, sts_tvalid 0, sts_tlast 0.
REQ-019 Reset mid-frame or mid-record SHALL discard partial frame and pending records; no partial status resumes.
REQ-020 During reset, pass-through outputs follow REQ-005/006 with fifo_full = 0.

Structure
REQ-021 Shared package axi_aes_pkg SHALL hold status flag constant 0x5000_0000, word count 5, count width 23, record field layout.
REQ-022 Record FIFO SHALL be a sub-module axi_aes_sts_fifo (synchronous, registered count, no first-word fall-through requirement beyond REQ-016).

Verification
REQ-023 Single frame 3 beats tkeep 0xFFFF,0xFFFF,0x00FF, sts_tready=1 -> 5 words, word4 = 0x28, word1 = 0, word2 = 0, tvalid at N+2.
REQ-024 Four frames back-to-back with sts_tready=0 -> fifth tlast beat stalls (aes_tready=0) until first record's word 4 accepted.
REQ-025 aes_terr=1 on middle beat of frame -> word2 = 0x1; next frame word2 = 0x0.
REQ-026 Force count to 0x7FFFF8 then beat tkeep 0xFFFF -> word4 = 0x7FFFFF, word2 = 0x2.
REQ-027 Random sts_tready toggling over 65537 frames -> words stable while stalled, seq wraps 0xFFFF -> 0x0000.
REQ-028 Assert s2mm_reset during word 2 of a record -> sts_tvalid 0 next cycle; following frame reports seq 0.
